data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised successor to the 8-bit data memory in the MIPS-8 datapath. Adds configurable width and depth, masked writes, read-valid signalling, range checking and a hardware clear sequence after reset.
- Sits between the ALU/address path and the writeback mux.
- Single port; one access (read, write, or read+write) per cycle.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 8: address bus width.
- DEPTH, 256: number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- wr_mask  input  DATA_WIDTH  per-bit write mask; 1 = update the bit.
- write_enable  input  1  write request.
- read_enable  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- read_valid  output  1  one-cycle pulse, aligned with updated data_out.
- busy  output  1  high while the clear sequence runs; requests are ignored.
- addr_error  output  1  one-cycle pulse for an out-of-range access.

Behaviour:
- Decided interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled at posedge clk) overrides everything:
  - state <= CLEAR, clr_ptr <= 0.
  - busy <= 1, data_out <= 0, read_valid <= 0, addr_error <= 0.
  - No array write occurs in a reset cycle.
- State CLEAR:
  - Each cycle writes 0 to ram[clr_ptr] and increments clr_ptr.
  - On the cycle writing ram[DEPTH-1], the next state is IDLE and busy <= 0.
  - busy deasserts exactly DEPTH cycles after the first cycle with reset low.
  - read_enable and write_enable are ignored; read_valid and addr_error stay 0.
- Reset asserted mid-CLEAR restarts the clear from address 0.
- State IDLE:
  - Read: read_enable=1 at edge N gives data_out = ram[address] and read_valid=1 after edge N (1-cycle latency).
  - read_valid returns to 0 on the next edge with no read. data_out holds its last value when no read occurs.
  - Write: write_enable=1 gives ram[address] <= (ram[address] & ~wr_mask) | (data_in & wr_mask).
  - wr_mask = all-zero is a no-op write.
- Simultaneous read and write (same or different address):
  - Both are performed.
  - The read is read-first: it returns the pre-write contents (unless DMEM_WR_FORWARD_EN is defined).
- Range check, address >= DEPTH (only possible when DEPTH < 2**ADDR_WIDTH):
  - Write is dropped.
  - Read returns data_out = 0 with read_valid = 1.
  - addr_error pulses for 1 cycle if either enable is set.
  - A combined read+write out of range gives a single addr_error pulse.
- Neither enable set: no state change except read_valid and addr_error clearing to 0.
- clr_ptr is sized to hold DEPTH-1 without overflow and never wraps past DEPTH-1.

Optional Feature:
- Macro: DMEM_WR_FORWARD_EN.
- Defined: a simultaneous read and in-range write to the same address returns the merged new word on data_out, i.e. (old & ~wr_mask) | (data_in & wr_mask). This is write-first behaviour.
- Undefined: read-first behaviour as specified above.
- The macro does not affect different-address accesses, the range check, or the clear sequence.

Test Plan:
- Clear after reset: assert reset 2 cycles, then release → busy=1 for exactly 256 cycles, then 0. After that, reads of addresses 0x00, 0x7F and 0xFF return 0x00 with read_valid=1 one cycle after each request.
- Write then read: write 0xA5 to 0x10 (wr_mask=0xFF), then read 0x10 next cycle → data_out=0xA5, read_valid high for exactly 1 cycle. data_out holds 0xA5 while idle.
- Masked write: 0x10 holds 0xA5; write data_in=0x0F with wr_mask=0xF0 → read returns 0x05.
- Same-address read+write: 0x20 holds 0x11; read+write 0x20 with 0x22 in one cycle → data_out=0x11 without the macro, 0x22 with DMEM_WR_FORWARD_EN. A subsequent read returns 0x22 in both builds.
- Out-of-range (DEPTH=200): write 0x55 to 0xC8, then read 0xC8 → addr_error pulses on each request, data_out=0x00 with read_valid=1. A read of 0xC7 is unaffected.
- Reset mid-clear and requests while busy:
  - Assert reset at clear cycle 100 → busy stays high a full 256 cycles after release.
  - A write issued while busy=1 is not stored; the read returns 0x00 after clear.
  - read_valid never asserts while busy=1.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data memory for the MIPS-8 datapath.
// It has a configurable word width and depth, per-bit masked writes, and a
// registered read with a read_valid pulse. Accesses outside DEPTH are dropped
// and flagged. After every reset a hardware sequence clears the whole array.
// Optional build macro: DMEM_WR_FORWARD_EN. When defined, a read and a write
// to the same address in one cycle return the newly merged word (write-first).
// When undefined, that read returns the old word (read-first).
module data_memory_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  addr_error
);

    // The clear pointer only has to reach DEPTH-1.
    localparam int CLR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CLR_W-1:0]      CLR_LAST  = CLR_W'(DEPTH - 1);
    localparam logic [CLR_W-1:0]      CLR_ONE   = CLR_W'(1);
    // DEPTH is widened by one bit, so DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_t                state_r;
    state_t                next_state_s;
    logic [CLR_W-1:0]      clr_ptr_r;

    logic                  in_range_s;
    logic [DATA_WIDTH-1:0] old_word_s;
    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  clr_wr_s;
    logic                  mem_we_s;
    logic                  rd_fire_s;
    logic                  err_s;

    // Address decode, fetch of the current word, and merge of the masked write.
    always_comb begin
        in_range_s = ({1'b0, address} < DEPTH_EXT);
        old_word_s = '0;
        if (in_range_s) begin
            old_word_s = mem_r[address];
        end else begin
            old_word_s = '0;
        end
        merged_s = (old_word_s & ~wr_mask) | (data_in & wr_mask);
    end

    // Next-state decode and per-cycle memory controls.
    always_comb begin
        next_state_s = state_r;
        clr_wr_s     = 1'b0;
        mem_we_s     = 1'b0;
        rd_fire_s    = 1'b0;
        err_s        = 1'b0;
        rd_data_s    = '0;
        case (state_r)
            ST_CLEAR: begin
                // Requests are ignored while the array is being cleared.
                clr_wr_s = 1'b1;
                if (clr_ptr_r == CLR_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                next_state_s = ST_IDLE;
                rd_fire_s    = read_enable;
                err_s        = (read_enable | write_enable) & ~in_range_s;
                mem_we_s     = write_enable & in_range_s;
                if (in_range_s) begin
`ifdef DMEM_WR_FORWARD_EN
                    if (write_enable) begin
                        rd_data_s = merged_s;
                    end else begin
                        rd_data_s = old_word_s;
                    end
`else
                    rd_data_s = old_word_s;
`endif
                end else begin
                    rd_data_s = '0;
                end
            end
            default: begin
                next_state_s = ST_CLEAR;
            end
        endcase
    end

    // FSM state, clear pointer and registered outputs. Reset restarts the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_CLEAR;
            clr_ptr_r  <= '0;
            busy       <= 1'b1;
            data_out   <= '0;
            read_valid <= 1'b0;
            addr_error <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (clr_wr_s && (clr_ptr_r != CLR_LAST)) begin
                clr_ptr_r <= clr_ptr_r + CLR_ONE;
            end
            busy       <= (next_state_s == ST_CLEAR);
            read_valid <= rd_fire_s;
            addr_error <= err_s;
            if (rd_fire_s) begin
                data_out <= rd_data_s;
            end
        end
    end

    // Array writes: the clear sequence first, then masked writes. A reset cycle never writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_wr_s) begin
                mem_r[clr_ptr_r] <= '0;
            end else if (mem_we_s) begin
                mem_r[address] <= merged_s;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed testbench for data_memory_ctrl.
// It drives a full-depth instance (DEPTH=256) and a short instance
// (DEPTH=200) from the same stimulus, so the clear length and the
// out-of-range behaviour can both be observed.
module tb_data_memory_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] address;
    logic [7:0] data_in;
    logic [7:0] wr_mask;
    logic       write_enable;
    logic       read_enable;

    logic [7:0] dout_b;
    logic       rv_b;
    logic       busy_b;
    logic       ae_b;
    logic [7:0] dout_t;
    logic       rv_t;
    logic       busy_t;
    logic       ae_t;

    int checks;
    int failures;

    data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256)) u_big (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .wr_mask(wr_mask), .write_enable(write_enable), .read_enable(read_enable),
        .data_out(dout_b), .read_valid(rv_b), .busy(busy_b), .addr_error(ae_b)
    );

    data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200)) u_small (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .wr_mask(wr_mask), .write_enable(write_enable), .read_enable(read_enable),
        .data_out(dout_t), .read_valid(rv_t), .busy(busy_t), .addr_error(ae_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] m);
        read_enable  = re;
        write_enable = we;
        address      = a;
        data_in      = d;
        wr_mask      = m;
    endtask

    int n_big;
    int n_small;
    int bad_rv;
    logic [7:0] exp_rw;

    initial begin
        checks   = 0;
        failures = 0;
        n_big    = 0;
        n_small  = 0;
        bad_rv   = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        chk("reset_busy", {31'd0, busy_b}, 32'd1);
        chk("reset_dout", {24'd0, dout_b}, 32'd0);
        chk("reset_rv", {31'd0, rv_b}, 32'd0);
        chk("reset_ae", {31'd0, ae_b}, 32'd0);

        // Release reset, then issue read+write requests while the clear runs.
        reset = 1'b0;
        drive(1'b1, 1'b1, 8'hD0, 8'h5A, 8'hFF);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rv_b || ae_b || rv_t || ae_t) bad_rv++;
        end
        chk("busy_at_100", {31'd0, busy_b}, 32'd1);

        // Reset in the middle of the clear: the sequence starts again from address 0.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (busy_t && (rv_t || ae_t)) bad_rv++;
            if (busy_b && (rv_b || ae_b)) bad_rv++;
            if (n_small == 0 && !busy_t) n_small = i;
            if (n_big == 0 && !busy_b) n_big = i;
            if (n_small != 0 && n_big != 0) break;
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("clr_cycles_256", n_big, 32'd256);
        chk("clr_cycles_200", n_small, 32'd200);
        chk("no_rv_while_busy", bad_rv, 32'd0);

        // Reads after the clear return zero with a one-cycle read_valid.
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("rd00_dout", {24'd0, dout_b}, 32'h00);
        chk("rd00_rv", {31'd0, rv_b}, 32'd1);
        drive(1'b1, 1'b0, 8'h7F, 8'h00, 8'h00);
        tick();
        chk("rd7f_dout", {24'd0, dout_b}, 32'h00);
        chk("rd7f_rv", {31'd0, rv_b}, 32'd1);
        drive(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
        tick();
        chk("rdff_dout", {24'd0, dout_b}, 32'h00);
        chk("rdff_rv", {31'd0, rv_b}, 32'd1);
        drive(1'b1, 1'b0, 8'hD0, 8'h00, 8'h00);
        tick();
        chk("busy_write_dropped", {24'd0, dout_b}, 32'h00);

        // A full write, a readback, and data_out holding its value while idle.
        drive(1'b0, 1'b1, 8'h10, 8'hA5, 8'hFF);
        tick();
        chk("wr_rv_low", {31'd0, rv_b}, 32'd0);
        drive(1'b1, 1'b0, 8'h10, 8'h00, 8'h00);
        tick();
        chk("rd10_dout", {24'd0, dout_b}, 32'hA5);
        chk("rd10_rv", {31'd0, rv_b}, 32'd1);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("idle_rv", {31'd0, rv_b}, 32'd0);
        chk("idle_hold", {24'd0, dout_b}, 32'hA5);

        // Masked write: (A5 & 0F) | (0F & F0) = 05.
        drive(1'b0, 1'b1, 8'h10, 8'h0F, 8'hF0);
        tick();
        drive(1'b1, 1'b0, 8'h10, 8'h00, 8'h00);
        tick();
        chk("masked", {24'd0, dout_b}, 32'h05);
        // A write with an all-zero mask leaves the word unchanged.
        drive(1'b0, 1'b1, 8'h10, 8'hFF, 8'h00);
        tick();
        drive(1'b1, 1'b0, 8'h10, 8'h00, 8'h00);
        tick();
        chk("zero_mask", {24'd0, dout_b}, 32'h05);

        // Read and write to the same address in one cycle.
        drive(1'b0, 1'b1, 8'h20, 8'h11, 8'hFF);
        tick();
        drive(1'b1, 1'b1, 8'h20, 8'h22, 8'hFF);
        tick();
`ifdef DMEM_WR_FORWARD_EN
        exp_rw = 8'h22;
`else
        exp_rw = 8'h11;
`endif
        chk("rw_same", {24'd0, dout_b}, {24'd0, exp_rw});
        drive(1'b1, 1'b0, 8'h20, 8'h00, 8'h00);
        tick();
        chk("rw_after", {24'd0, dout_b}, 32'h22);

        // Out-of-range accesses on the DEPTH=200 instance.
        drive(1'b0, 1'b1, 8'hC8, 8'h55, 8'hFF);
        tick();
        chk("oor_wr_ae", {31'd0, ae_t}, 32'd1);
        chk("inrange_wr_ae_big", {31'd0, ae_b}, 32'd0);
        drive(1'b1, 1'b0, 8'hC8, 8'h00, 8'h00);
        tick();
        chk("oor_rd_dout", {24'd0, dout_t}, 32'h00);
        chk("oor_rd_rv", {31'd0, rv_t}, 32'd1);
        chk("oor_rd_ae", {31'd0, ae_t}, 32'd1);
        chk("big_c8", {24'd0, dout_b}, 32'h55);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("oor_ae_clear", {31'd0, ae_t}, 32'd0);
        chk("oor_rv_clear", {31'd0, rv_t}, 32'd0);
        drive(1'b0, 1'b1, 8'hC7, 8'h66, 8'hFF);
        tick();
        chk("c7_wr_ae", {31'd0, ae_t}, 32'd0);
        drive(1'b1, 1'b0, 8'hC7, 8'h00, 8'h00);
        tick();
        chk("c7_rd_dout", {24'd0, dout_t}, 32'h66);
        chk("c7_rd_ae", {31'd0, ae_t}, 32'd0);
        drive(1'b1, 1'b1, 8'hE0, 8'h77, 8'hFF);
        tick();
        chk("oor_rw_ae", {31'd0, ae_t}, 32'd1);
        chk("oor_rw_dout", {24'd0, dout_t}, 32'h00);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("oor_rw_single", {31'd0, ae_t}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
